fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter_if.sv | 39 +++
 rtl/fp_add_arbiter.sv | 148 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_if.sv
// Requester and adder-side signal bundle for the two-port adder arbiter.
interface fp_add_arbiter_if;
    localparam int unsigned DATA_W = 32;

    logic              req0;
    logic              req1;
    logic              u0;
    logic              v0;
    logic              u1;
    logic              v1;
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] y0;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] y1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] zr;
    logic              err;
    logic              busy;
    logic              fa_run;
    logic              fa_u;
    logic              fa_v;
    logic [DATA_W-1:0] fa_x;
    logic [DATA_W-1:0] fa_y;
    logic              fa_stall;
    logic [DATA_W-1:0] fa_z;

    // Arbiter view
    modport slave (
        input  req0, req1, u0, v0, u1, v1, x0, y0, x1, y1, fa_stall, fa_z,
        output ack0, ack1, zr, err, busy, fa_run, fa_u, fa_v, fa_x, fa_y
    );

    // Requesters plus adder view
    modport master (
        output req0, req1, u0, v0, u1, v1, x0, y0, x1, y1, fa_stall, fa_z,
        input  ack0, ack1, zr, err, busy, fa_run, fa_u, fa_v, fa_x, fa_y
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle adder between two requesters,
// with a watchdog that aborts a run stuck in stall.
module fp_add_arbiter #(
    parameter int unsigned MAXCYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    fp_add_arbiter_if.slave    bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXCYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gnt_q, gnt_d;     // requester being served
    logic                last_q, last_d;   // requester granted most recently
    logic                run_q, run_d;
    logic                busy_q, busy_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   zr_q, zr_d;
    logic                fu_q, fu_d;
    logic                fv_q, fv_d;
    logic [DATA_W-1:0]   fx_q, fx_d;
    logic [DATA_W-1:0]   fy_q, fy_d;
    logic                pick_c;
    logic                finish_c;

    // Next-state, grant selection and completion handling
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        run_d    = run_q;
        busy_d   = busy_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err_d    = err_q;
        zr_d     = zr_q;
        fu_d     = fu_q;
        fv_d     = fv_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        finish_c = 1'b0;
        // Tie goes to the requester not served last; otherwise whoever asks
        pick_c   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d   = pick_c;
                    last_d  = pick_c;
                    fu_d    = pick_c ? bus.u1 : bus.u0;
                    fv_d    = pick_c ? bus.v1 : bus.v0;
                    fx_d    = pick_c ? bus.x1 : bus.x0;
                    fy_d    = pick_c ? bus.y1 : bus.y0;
                    cnt_d   = '0;
                    run_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.fa_stall) begin
                    zr_d     = bus.fa_z;
                    err_d    = 1'b0;
                    finish_c = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    zr_d     = '0;
                    err_d    = 1'b1;
                    finish_c = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
                if (finish_c) begin
                    run_d   = 1'b0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                run_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves pointer on requester 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            zr_q    <= '0;
            fu_q    <= 1'b0;
            fv_q    <= 1'b0;
            fx_q    <= '0;
            fy_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            zr_q    <= zr_d;
            fu_q    <= fu_d;
            fv_q    <= fv_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
        end
    end

    assign bus.fa_run = run_q;
    assign bus.busy   = busy_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.err    = err_q;
    assign bus.zr     = zr_q;
    assign bus.fa_u   = fu_q;
    assign bus.fa_v   = fv_q;
    assign bus.fa_x   = fx_q;
    assign bus.fa_y   = fy_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a stalling adder model.
module tb_fp_add_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_len = 3;
    int   run_cnt = 0;

    fp_add_arbiter_if bus();

    fp_add_arbiter #(.MAXCYC(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Adder model: 1.0+2.0 gives 3.0, anything else an integer sum tagged by u/v
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic u, input logic v);
        if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
        return x + y + {30'b0, u, v};
    endfunction

    // Stall is released after stall_len RUN cycles
    always @(posedge clk) run_cnt <= bus.fa_run ? run_cnt + 1 : 0;
    assign bus.fa_stall = bus.fa_run && (run_cnt < stall_len);
    assign bus.fa_z     = model(bus.fa_x, bus.fa_y, bus.fa_u, bus.fa_v);

    typedef struct {
        logic        req0, req1;
        logic        u0, v0, u1, v1;
        logic [31:0] x0, y0, x1, y1;
        int          exp_who;
        logic [31:0] exp_fx;
        logic [31:0] exp_zr;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.u0 = 1'b0; bus.v0 = 1'b0; bus.u1 = 1'b0; bus.v1 = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    endtask

    // Step until an ack appears; who=-1 on timeout
    task automatic wait_ack(output int cyc, output int who);
        cyc = 0;
        who = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            cyc++;
            if (bus.ack0 || bus.ack1) begin
                who = bus.ack1 ? 1 : 0;
                break;
            end
        end
        if (who < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got none expected ack within 60 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        #2 rst = 1'b0;
    endtask

    initial begin
        int cyc, who, runs, lows;

        clear_inputs();
        vecs[0] = '{1,0, 0,0,0,0, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 32'h3F80_0000, 32'h4040_0000};
        vecs[1] = '{1,1, 0,0,1,0, 32'h1, 32'h2, 32'h10, 32'h20, 1, 32'h10, 32'h32};
        vecs[2] = '{1,1, 1,1,0,0, 32'h5, 32'h7, 32'h9, 32'h9, 0, 32'h5, 32'hF};
        vecs[3] = '{0,1, 0,0,0,0, 32'h0, 32'h0, 32'h100, 32'h1, 1, 32'h100, 32'h101};
        vecs[4] = '{0,1, 0,0,0,0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h2, 1, 32'hFFFF_FFFF, 32'h1};
        vecs[5] = '{1,1, 0,0,0,0, 32'h3F80_0000, 32'h4000_0000, 32'h7, 32'h7, 0, 32'h3F80_0000, 32'h4040_0000};

        // Reset state
        step();
        check("rst_fa_run", 32'(bus.fa_run), 0);
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_acks",   32'({bus.ack0, bus.ack1}), 0);
        check("rst_zr",     bus.zr, 0);
        check("rst_err",    32'(bus.err), 0);
        check("rst_fa_x",   bus.fa_x, 0);
        check("rst_fa_y",   bus.fa_y, 0);
        check("rst_fa_uv",  32'({bus.fa_u, bus.fa_v}), 0);
        #2 rst = 1'b0;
        step();
        check("idle_busy", 32'(bus.busy), 0);

        // Table-driven single operations; requests dropped right after grant
        foreach (vecs[i]) begin
            bus.req0 = vecs[i].req0; bus.req1 = vecs[i].req1;
            bus.u0 = vecs[i].u0; bus.v0 = vecs[i].v0;
            bus.u1 = vecs[i].u1; bus.v1 = vecs[i].v1;
            bus.x0 = vecs[i].x0; bus.y0 = vecs[i].y0;
            bus.x1 = vecs[i].x1; bus.y1 = vecs[i].y1;
            step();
            check($sformatf("v%0d_fa_run", i), 32'(bus.fa_run), 1);
            check($sformatf("v%0d_fa_x", i), bus.fa_x, vecs[i].exp_fx);
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            wait_ack(cyc, who);
            check($sformatf("v%0d_latency", i), 32'(cyc), 4);
            check($sformatf("v%0d_who", i), 32'(who), 32'(vecs[i].exp_who));
            check($sformatf("v%0d_both_ack", i), 32'(bus.ack0 & bus.ack1), 0);
            check($sformatf("v%0d_zr", i), bus.zr, vecs[i].exp_zr);
            check($sformatf("v%0d_err", i), 32'(bus.err), 0);
            step();
            check($sformatf("v%0d_ack_pulse", i), 32'({bus.ack0, bus.ack1}), 0);
            check($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 0);
            check($sformatf("v%0d_zr_hold", i), bus.zr, vecs[i].exp_zr);
        end

        // Operand isolation plus a withdrawn req1 pulse while busy
        bus.req0 = 1'b1; bus.x0 = 32'h3F80_0000; bus.y0 = 32'h4000_0000;
        step();
        bus.x0 = 32'hFFFF_FFFF; bus.req0 = 1'b0; bus.req1 = 1'b1;
        bus.x1 = 32'h55; bus.y1 = 32'h1;
        step();
        bus.req1 = 1'b0;
        check("iso_fa_x_r2", bus.fa_x, 32'h3F80_0000);
        wait_ack(cyc, who);
        check("iso_who", 32'(who), 0);
        check("iso_zr", bus.zr, 32'h4040_0000);
        check("iso_fa_x_done", bus.fa_x, 32'h3F80_0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("wd_req1_idle%0d", i), 32'({bus.busy, bus.ack1}), 0);
        end

        // Watchdog: stall stuck high, then a normal op
        stall_len = 1000;
        bus.req0 = 1'b1; bus.x0 = 32'h3; bus.y0 = 32'h4;
        step();
        bus.req0 = 1'b0;
        runs = 0;
        for (int i = 0; i < 40 && bus.fa_run; i++) begin
            runs++;
            step();
        end
        check("wdog_runs", 32'(runs), 15);
        check("wdog_ack0", 32'(bus.ack0), 1);
        check("wdog_zr", bus.zr, 0);
        check("wdog_err", 32'(bus.err), 1);
        stall_len = 3;
        step();
        bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        wait_ack(cyc, who);
        check("wdog_next_who", 32'(who), 0);
        check("wdog_next_zr", bus.zr, 32'h7);
        check("wdog_next_err", 32'(bus.err), 0);
        step();

        // Tie from reset: grants alternate 0,1,0,1 with run low >=2 cycles between
        do_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.x0 = 32'h10; bus.y0 = 32'h0; bus.x1 = 32'h20; bus.y1 = 32'h0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc, who);
            check($sformatf("tie_who%0d", k), 32'(who), 32'(k % 2));
            check($sformatf("tie_zr%0d", k), bus.zr, (k % 2) ? 32'h20 : 32'h10);
            lows = 0;
            for (int i = 0; i < 10 && !bus.fa_run; i++) begin
                lows++;
                step();
            end
            check($sformatf("tie_gap%0d", k), 32'(lows >= 2), 1);
        end
        clear_inputs();
        wait_ack(cyc, who);
        step();

        // Reset during the second RUN cycle, req1 pending afterwards
        bus.req0 = 1'b1; bus.x0 = 32'h1; bus.y0 = 32'h1;
        step();
        bus.req0 = 1'b0;
        step();
        bus.req1 = 1'b1; bus.x1 = 32'h40; bus.y1 = 32'h2;
        rst = 1'b1;
        #1;
        check("mrst_fa_run", 32'(bus.fa_run), 0);
        check("mrst_busy", 32'(bus.busy), 0);
        check("mrst_acks", 32'({bus.ack0, bus.ack1}), 0);
        #1 rst = 1'b0;
        step();
        check("mrst_regrant_run", 32'(bus.fa_run), 1);
        check("mrst_regrant_x", bus.fa_x, 32'h40);
        bus.req1 = 1'b0;
        wait_ack(cyc, who);
        check("mrst_who", 32'(who), 1);
        check("mrst_zr", bus.zr, 32'h42);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
